rename_ctl: RTL and testbench

//  Rename controller for the register alias table (RAT). Owns the physical tag free

---
 rtl/rename_ctl.sv | 197 +++++++++++++++++++
 tb/tb_rename_ctl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_ctl.sv
// rename_ctl -- rename controller for the register alias table (RAT).
//
// Owns the physical tag free list (circular FIFO, reset to tags 0..NTAGS-1 in
// order) and hands the RAT one destination tag per rename. On a mispredict
// flush it walks every architectural register, force-setting each RAT entry
// from the retirement register file (ARF), then force-sets the flags entry and
// reinitialises the free list.
//
// Optional feature macro: RENAME_CTL_FREE_BYPASS_EN
//   When defined, a tag freed in the same cycle the free list is empty can be
//   handed straight to a rename.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   ren_valid/ren_ready   rename handshake
//   ren_has_res           rename writes a result register (allocates a tag)
//   ren_wr_flags          rename writes flags
//   ren_res_reg           destination architectural register
//   ren_tag               tag for this rename
//   tag_free_en/tag_free  retire returns a tag to the free list
//   flush_req             mispredict recovery request
//   flush_busy/flush_done recovery in progress / one-cycle completion pulse
//   arf_addr, arf_data    ARF read port (data one cycle after address)
//   arf_flags             committed flags
//   rat_*                 RAT write port (rename writes and force-sets)
module rename_ctl #(
    parameter int DATAW    = 32,
    parameter int TAGW     = 6,
    parameter int REGADDRW = 5,
    parameter int FLAGSW   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ren_valid,
    output logic                ren_ready,
    input  logic                ren_has_res,
    input  logic                ren_wr_flags,
    input  logic [REGADDRW-1:0] ren_res_reg,
    output logic [TAGW-1:0]     ren_tag,
    input  logic                tag_free_en,
    input  logic [TAGW-1:0]     tag_free,
    input  logic                flush_req,
    output logic                flush_busy,
    output logic                flush_done,
    output logic [REGADDRW-1:0] arf_addr,
    input  logic [DATAW-1:0]    arf_data,
    input  logic [FLAGSW-1:0]   arf_flags,
    output logic                rat_en,
    output logic [REGADDRW-1:0] rat_res_reg,
    output logic [TAGW-1:0]     rat_res_tag,
    output logic                rat_res_en,
    output logic                rat_flags_en,
    output logic                rat_force_set,
    output logic                rat_force_set_flags,
    output logic [DATAW-1:0]    rat_force_value
);

    localparam int NTAGS = 2 ** TAGW;
    localparam int NREGS = 2 ** REGADDRW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_FLAGS,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [TAGW-1:0]     r_fifo [NTAGS];
    logic [TAGW-1:0]     r_head;
    logic [TAGW-1:0]     r_tail;
    logic [TAGW:0]       r_count;
    logic [REGADDRW:0]   r_idx;     // walk step, 0..NREGS

    logic                w_idle;
    logic                w_empty;
    logic                w_full;
    logic                w_bypass;
    logic                w_ready;
    logic                w_fire;
    logic                w_alloc;
    logic                w_byp_use;
    logic                w_pop;
    logic                w_push;
    logic                w_walk_wr;
    logic [TAGW-1:0]     w_tag;

    assign w_idle  = (r_state == S_IDLE);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (TAGW+1)'(NTAGS));

`ifdef RENAME_CTL_FREE_BYPASS_EN
    // Empty list but a tag is being returned right now: offer it directly.
    assign w_bypass = w_idle & w_empty & tag_free_en;
`else
    assign w_bypass = 1'b0;
`endif

    // A flush request wins over a rename in the same cycle.
    assign w_ready   = w_idle & ~flush_req & (~w_empty | w_bypass);
    assign w_fire    = ren_valid & w_ready;
    assign w_alloc   = w_fire & ren_has_res;
    assign w_byp_use = w_bypass & w_alloc;
    // Flags-only renames peek at the head tag without consuming it.
    assign w_pop     = w_alloc & ~w_byp_use;
    // A full list can still take a push when the same cycle pops (slot reuse).
    assign w_push    = w_idle & tag_free_en & ~w_byp_use & (~w_full | w_pop);
    assign w_tag     = w_bypass ? tag_free : r_fifo[r_head];

    // Walk step k>=1 writes register k-1 with the ARF data read in step k-1.
    assign w_walk_wr = (r_state == S_WALK) & (r_idx != '0);

    assign ren_ready           = w_ready;
    assign ren_tag             = w_tag;
    assign rat_res_tag         = w_tag;
    assign rat_res_en          = w_alloc;
    assign rat_flags_en        = w_fire & ren_wr_flags;
    assign rat_en              = w_alloc | w_walk_wr;
    assign rat_force_set       = w_walk_wr;
    assign rat_force_set_flags = (r_state == S_FLAGS);
    assign flush_busy          = ~w_idle;
    assign flush_done          = (r_state == S_DONE);
    // Last walk step (idx==NREGS) wraps the low bits to 0; no read is needed there.
    assign arf_addr            = (r_state == S_WALK) ? r_idx[REGADDRW-1:0] : '0;

    always_comb begin
        rat_res_reg = '0;
        if (w_idle) begin
            rat_res_reg = ren_res_reg;
        end else if (w_walk_wr) begin
            // idx==NREGS has zero low bits, so the subtraction wraps to NREGS-1.
            rat_res_reg = r_idx[REGADDRW-1:0] - 1'b1;
        end
    end

    always_comb begin
        rat_force_value = '0;
        if (w_walk_wr) begin
            rat_force_value = arf_data;
        end else if (r_state == S_FLAGS) begin
            rat_force_value = {{(DATAW-FLAGSW){1'b0}}, arf_flags};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= (TAGW+1)'(NTAGS);
            r_idx   <= '0;
            for (int i = 0; i < NTAGS; i++) begin
                r_fifo[i] <= TAGW'(i);
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_push) begin
                        r_fifo[r_tail] <= tag_free;
                        r_tail         <= r_tail + 1'b1;
                    end
                    if (w_pop) begin
                        r_head <= r_head + 1'b1;
                    end
                    r_count <= r_count + {{TAGW{1'b0}}, w_push} - {{TAGW{1'b0}}, w_pop};
                    if (flush_req) begin
                        r_state <= S_WALK;
                        r_idx   <= '0;
                    end
                end
                S_WALK: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == (REGADDRW+1)'(NREGS)) begin
                        r_state <= S_FLAGS;
                    end
                end
                S_FLAGS: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    // Every in-flight tag died with the flush: rebuild the full list.
                    r_head  <= '0;
                    r_tail  <= '0;
                    r_count <= (TAGW+1)'(NTAGS);
                    for (int i = 0; i < NTAGS; i++) begin
                        r_fifo[i] <= TAGW'(i);
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rename_ctl.sv
// Testbench for rename_ctl: directed stimulus with literal expectations, plus
// a queue-based model of the free list and a flush phase counter checked
// against the DUT on every negative clock edge.
module tb_rename_ctl;

    localparam int DATAW    = 32;
    localparam int TAGW     = 6;
    localparam int REGADDRW = 5;
    localparam int FLAGSW   = 4;
    localparam int NTAGS    = 2 ** TAGW;
    localparam int NREGS    = 2 ** REGADDRW;

`ifdef RENAME_CTL_FREE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic                ren_valid;
    logic                ren_ready;
    logic                ren_has_res;
    logic                ren_wr_flags;
    logic [REGADDRW-1:0] ren_res_reg;
    logic [TAGW-1:0]     ren_tag;
    logic                tag_free_en;
    logic [TAGW-1:0]     tag_free;
    logic                flush_req;
    logic                flush_busy;
    logic                flush_done;
    logic [REGADDRW-1:0] arf_addr;
    logic [DATAW-1:0]    arf_data;
    logic [FLAGSW-1:0]   arf_flags;
    logic                rat_en;
    logic [REGADDRW-1:0] rat_res_reg;
    logic [TAGW-1:0]     rat_res_tag;
    logic                rat_res_en;
    logic                rat_flags_en;
    logic                rat_force_set;
    logic                rat_force_set_flags;
    logic [DATAW-1:0]    rat_force_value;

    rename_ctl #(
        .DATAW(DATAW), .TAGW(TAGW), .REGADDRW(REGADDRW), .FLAGSW(FLAGSW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ren_valid(ren_valid), .ren_ready(ren_ready),
        .ren_has_res(ren_has_res), .ren_wr_flags(ren_wr_flags),
        .ren_res_reg(ren_res_reg), .ren_tag(ren_tag),
        .tag_free_en(tag_free_en), .tag_free(tag_free),
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
        .arf_addr(arf_addr), .arf_data(arf_data), .arf_flags(arf_flags),
        .rat_en(rat_en), .rat_res_reg(rat_res_reg), .rat_res_tag(rat_res_tag),
        .rat_res_en(rat_res_en), .rat_flags_en(rat_flags_en),
        .rat_force_set(rat_force_set), .rat_force_set_flags(rat_force_set_flags),
        .rat_force_value(rat_force_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ARF: register r holds r+100, one-cycle read latency.
    always @(posedge clk) arf_data <= 32'(arf_addr) + 32'd100;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int fl[$];     // free tags, front = next to allocate
    int ph = -1;   // -1 idle; else cycles since flush acceptance (0..NREGS+2)

    task automatic fl_reset();
        fl.delete();
        for (int i = 0; i < NTAGS; i++) fl.push_back(i);
    endtask

    int  m_sz;
    bit  m_byp, m_rdy, m_fire, m_pop, m_use;
    always @(posedge clk) begin
        if (!rst_n) begin
            fl_reset();
            ph = -1;
        end else if (ph >= 0) begin
            if (ph == NREGS + 2) begin
                ph = -1;
                fl_reset();
            end else begin
                ph++;
            end
        end else begin
            m_sz   = fl.size();
            m_byp  = BYP && m_sz == 0 && tag_free_en;
            m_rdy  = !flush_req && (m_sz != 0 || m_byp);
            m_fire = ren_valid && m_rdy;
            m_pop  = 1'b0;
            m_use  = 1'b0;
            if (m_fire && ren_has_res) begin
                if (m_byp) m_use = 1'b1;
                else begin
                    void'(fl.pop_front());
                    m_pop = 1'b1;
                end
            end
            if (tag_free_en && !m_use && (m_sz < NTAGS || m_pop)) fl.push_back(int'(tag_free));
            if (flush_req) ph = 0;
        end
    end

    int  c_sz;
    bit  c_byp, c_rdy, c_fire;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ph < 0) begin
                c_sz   = fl.size();
                c_byp  = BYP && c_sz == 0 && tag_free_en;
                c_rdy  = !flush_req && (c_sz != 0 || c_byp);
                c_fire = ren_valid && c_rdy;
                chk("m_ready", ren_ready, c_rdy);
                chk("m_busy", flush_busy, 0);
                chk("m_done", flush_done, 0);
                chk("m_rat_en", rat_en, c_fire && ren_has_res);
                chk("m_res_en", rat_res_en, c_fire && ren_has_res);
                chk("m_flags_en", rat_flags_en, c_fire && ren_wr_flags);
                chk("m_fset", rat_force_set, 0);
                chk("m_fset_flags", rat_force_set_flags, 0);
                if (c_rdy) begin
                    chk("m_ren_tag", ren_tag, c_byp ? int'(tag_free) : fl[0]);
                    chk("m_rat_tag", rat_res_tag, c_byp ? int'(tag_free) : fl[0]);
                end
                if (c_fire && ren_has_res) chk("m_res_reg", rat_res_reg, ren_res_reg);
            end else begin
                chk("m_ready", ren_ready, 0);
                chk("m_busy", flush_busy, 1);
                chk("m_done", flush_done, ph == NREGS + 2);
                chk("m_rat_en", rat_en, ph >= 1 && ph <= NREGS);
                chk("m_fset", rat_force_set, ph >= 1 && ph <= NREGS);
                chk("m_fset_flags", rat_force_set_flags, ph == NREGS + 1);
                chk("m_res_en", rat_res_en, 0);
                chk("m_flags_en", rat_flags_en, 0);
                if (ph < NREGS) chk("m_arf_addr", arf_addr, ph);
                if (ph >= 1 && ph <= NREGS) begin
                    chk("m_walk_reg", rat_res_reg, ph - 1);
                    chk("m_walk_val", rat_force_value, ph - 1 + 100);
                end
                if (ph == NREGS + 1) chk("m_flags_val", rat_force_value, arf_flags);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle_inputs();
        ren_valid = 0; ren_has_res = 0; ren_wr_flags = 0; ren_res_reg = '0;
        tag_free_en = 0; tag_free = '0; flush_req = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 idle_inputs(); rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
    endtask

    initial begin
        idle_inputs();
        arf_flags = 4'hA;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1;
        chk("rst_ready", ren_ready, 1);
        chk("rst_tag", ren_tag, 0);
        chk("rst_busy", flush_busy, 0);
        chk("rst_done", flush_done, 0);
        chk("rst_rat_en", rat_en, 0);
        chk("rst_fval", rat_force_value, 0);
        chk("rst_arf_addr", arf_addr, 0);

        // First renames get tags 0 then 1.
        @(posedge clk); #1 ren_valid = 1; ren_has_res = 1; ren_res_reg = 5'd3;
        #1 chk("r3_tag", ren_tag, 0); chk("r3_rat_en", rat_en, 1); chk("r3_reg", rat_res_reg, 3);
        @(posedge clk); #1 ren_res_reg = 5'd4;
        #1 chk("r4_tag", ren_tag, 1);
        @(posedge clk); #1 idle_inputs();

        // Drain all 64 tags in order, then ready drops.
        do_reset();
        for (int i = 0; i < NTAGS; i++) begin
            @(posedge clk); #1 ren_valid = 1; ren_has_res = 1; ren_res_reg = 5'(i);
            #1 chk("drain_tag", ren_tag, i);
        end
        @(posedge clk); #1 idle_inputs();
        #1 chk("empty_ready", ren_ready, 0);
        @(posedge clk); #1 tag_free_en = 1; tag_free = 6'd9;
        @(posedge clk); #1 idle_inputs(); ren_valid = 1; ren_has_res = 1;
        #1 chk("refill_ready", ren_ready, 1); chk("refill_tag", ren_tag, 9);
        @(posedge clk); #1 idle_inputs();
        #1 chk("reempty_ready", ren_ready, 0);

        // Empty list with a same-cycle free and rename.
        @(posedge clk); #1 tag_free_en = 1; tag_free = 6'd17; ren_valid = 1; ren_has_res = 1;
        #1 chk("byp_ready", ren_ready, BYP);
`ifdef RENAME_CTL_FREE_BYPASS_EN
        chk("byp_tag", ren_tag, 17);
        chk("byp_rat_en", rat_en, 1);
`else
        chk("nobyp_rat_en", rat_en, 0);
`endif
        @(posedge clk); #1 idle_inputs();
        #1 chk("byp_after_ready", ren_ready, !BYP);

        // Flags-only rename does not consume the head tag.
        do_reset();
        @(posedge clk); #1 ren_valid = 1; ren_wr_flags = 1;
        #1 chk("fo_flags_en", rat_flags_en, 1); chk("fo_rat_en", rat_en, 0); chk("fo_tag", ren_tag, 0);
        @(posedge clk); #1 ren_wr_flags = 0; ren_has_res = 1;
        #1 chk("fo_next_tag", ren_tag, 0);
        @(posedge clk); #1;
        #1 chk("fo_next2_tag", ren_tag, 1);

        // Flush beats a same-cycle rename.
        @(posedge clk); #1 flush_req = 1;
        #1 chk("fl_ready", ren_ready, 0); chk("fl_rat_en", rat_en, 0);
        // Acceptance edge has just passed; a free here must be dropped.
        @(posedge clk); #1 idle_inputs(); tag_free_en = 1; tag_free = 6'd5;
        #1 chk("fl_busy", flush_busy, 1);
        for (int n = 1; n <= NREGS + 2; n++) begin
            @(posedge clk); #1 idle_inputs();
            #1 chk("fl_done_time", flush_done, n == NREGS + 2);
            if (n == 1) begin
                chk("fl_w0_reg", rat_res_reg, 0); chk("fl_w0_val", rat_force_value, 100);
            end
            if (n == NREGS) begin
                chk("fl_w31_reg", rat_res_reg, 31); chk("fl_w31_val", rat_force_value, 131);
            end
            if (n == NREGS + 1) begin
                chk("fl_flags_set", rat_force_set_flags, 1); chk("fl_flags_val", rat_force_value, 32'hA);
            end
        end
        @(posedge clk); #1 ren_valid = 1; ren_has_res = 1;
        #1 chk("post_fl_ready", ren_ready, 1); chk("post_fl_tag", ren_tag, 0); chk("post_fl_done", flush_done, 0);
        @(posedge clk); #1 idle_inputs();

        // Reset in the middle of a walk aborts with no done pulse.
        @(posedge clk); #1 flush_req = 1;
        @(posedge clk); #1 flush_req = 0;
        repeat (5) @(posedge clk);
        #1 chk("mid_busy_before", flush_busy, 1);
        rst_n = 0;
        #1 chk("mid_busy", flush_busy, 0); chk("mid_done", flush_done, 0);
        chk("mid_ready", ren_ready, 1); chk("mid_rat_en", rat_en, 0);
        @(posedge clk); #1 rst_n = 1;
        for (int n = 0; n < NREGS + 4; n++) begin
            @(posedge clk); #1;
            #1 chk("mid_no_done", flush_done, 0);
        end
        @(posedge clk); #1 ren_valid = 1; ren_has_res = 1;
        #1 chk("mid_tag", ren_tag, 0);
        @(posedge clk); #1 idle_inputs();
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
